// File: rtl/uart_rx_if.sv
// uart_rx_if: valid/ready byte stream carrying received bytes out of the FIFO
interface uart_rx_if;
  logic [7:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling and a first-word-fall-through FIFO
module uart_rx #(
  parameter int CLK_FREQ = 24_000_000,
  parameter int UART_BOUD_RATE = 9600,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_pin,
  uart_rx_if.master bus,
  output logic framing_error,
  output logic overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);
  localparam int UART_CYCLE = CLK_FREQ / UART_BOUD_RATE;
  localparam int HALF = UART_CYCLE / 2;
  localparam int CW = UART_CYCLE > 2 ? $clog2(UART_CYCLE) : 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state;
  logic s1, rx_s, bit_end, push, pop, full, wr;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sr;
  logic [7:0] mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wp, rp;
  assign bit_end = cnt == CW'(UART_CYCLE - 1);
  assign push = state == STOP && bit_end && rx_s;
  assign pop = bus.valid && bus.ready;
  assign full = fifo_count == (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  assign wr = push && (!full || pop);
  assign bus.valid = fifo_count != '0;
  assign bus.data = bus.valid ? mem[rp] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s, s1} <= 2'b11;
    else {rx_s, s1} <= {s1, rx_pin};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sr <= '0;
      framing_error <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == CW'(HALF)) begin
          cnt <= '0;
          idx <= '0;
          state <= rx_s ? IDLE : DATA;
        end else cnt <= cnt + CW'(1);
        DATA: if (bit_end) begin
          cnt <= '0;
          sr <= {rx_s, sr[7:1]};
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= STOP;
        end else cnt <= cnt + CW'(1);
        STOP: if (bit_end) begin
          cnt <= '0;
          state <= rx_s ? IDLE : BRK;
          framing_error <= !rx_s;
        end else cnt <= cnt + CW'(1);
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= sr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + (FIFO_DEPTH_LOG2 + 1)'(wr) - (FIFO_DEPTH_LOG2 + 1)'(pop);
    end
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the OFDM FPGA design: the receiving end of the 8N1 serial link that `top` drives on `tx_pin`. It synchronises `rx_pin`, recovers bytes by mid-bit sampling at a fixed baud, and buffers them in a first-word-fall-through FIFO with a valid/ready output. It serves as the host-command input path and as the loopback checker for the transmitter in system benches.

## Interface

Parameters:
- `CLK_FREQ`, 24_000_000: system clock frequency in Hz.
- `UART_BOUD_RATE`, 9600: baud rate in bit/s.
- `FIFO_DEPTH_LOG2`, 4: FIFO depth is 2^FIFO_DEPTH_LOG2 entries (16).

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rx_pin` input 1: serial line, idle high, asynchronous to `clk`.
- `data` output 8: byte at FIFO head; valid only while `valid`=1.
- `valid` output 1: FIFO not empty.
- `ready` input 1: consumer accepts `data` when `valid` and `ready` are both 1.
- `framing_error` output 1: one-cycle pulse when the stop bit samples 0.
- `overflow` output 1: one-cycle pulse when a received byte is dropped because the FIFO is full.
- `fifo_count` output FIFO_DEPTH_LOG2+1: current FIFO occupancy.

## Operation

- `UART_CYCLE = CLK_FREQ / UART_BOUD_RATE` (integer division). `HALF = UART_CYCLE / 2`. The bit counter width covers UART_CYCLE-1.
- Synchroniser: 2 flip-flops, both reset to 1. The FSM uses only the synchronised signal `rx_s`.
- FSM states:
  - IDLE: on `rx_s`=0, clear the counter and go to START.
  - START: count HALF cycles, then sample. If `rx_s`=1, treat it as a glitch and return to IDLE with no output. Otherwise clear the counter and bit index, then go to DATA.
  - DATA: every UART_CYCLE cycles, sample `rx_s` into the shift register LSB-first. After bit 7, go to STOP.
  - STOP: after UART_CYCLE cycles, sample.
    - If 1: push the byte and return to IDLE. The FSM does not wait out the stop bit, so back-to-back frames are accepted.
    - If 0: pulse `framing_error`, discard the byte, and go to BREAK.
  - BREAK: wait until `rx_s`=1, then go to IDLE.
- FIFO: circular buffer with read and write pointers of FIFO_DEPTH_LOG2 bits that wrap modulo depth, and a separate occupancy count.
  - Push when full without a same-cycle pop: the byte is dropped, `overflow` pulses, and the contents are unchanged.
  - Push and pop in the same cycle: both happen and the count is unchanged. This includes the full case, where the push is accepted.
  - Pop when empty cannot occur, because `valid`=0.
- `data` comes from the FIFO head combinationally (registered memory, FWFT). It holds its value while `valid` && !`ready`.
- Reset, including mid-frame: FSM goes to IDLE, pointers and count go to 0, the synchroniser goes to 1. Any partial byte is lost.

## Timing

- Reset values: `valid`=0, `data`=0, `framing_error`=0, `overflow`=0, `fifo_count`=0.
- A falling edge on `rx_pin` is captured at `rx_s` 2 clocks later, at detection cycle D. START is entered at D+1.
- Start sample at D+1+HALF. Data bit k is sampled at D+1+HALF+(k+1)·UART_CYCLE. The stop bit is sampled at D+1+HALF+9·UART_CYCLE = S.
- The FIFO write is visible at S+1: `valid`=1 and `data`=byte, if the FIFO was empty. `fifo_count` increments at S+1.
- `framing_error` and `overflow` are high for exactly the cycle S+1.
- A pop at edge E updates `data`, `valid` and `fifo_count` from E+1.
- Any clock frequency error up to ±2% from the nominal baud must still sample inside each bit.

## Test plan

Bench parameters: CLK_FREQ=24_000_000, UART_BOUD_RATE=1_000_000 (UART_CYCLE=24), `ready`=1 unless stated otherwise.

1. Single frame 0x55, then 0xA3 -> `data`=0x55 then 0xA3. `valid` rises exactly at S+1 for each. No error pulses.
2. Glitch: `rx_pin` low for 8 cycles, then high -> the FSM returns to IDLE. No `valid`, no `framing_error`.
3. Frame 0x0F with stop bit 0, held low for 3 bit times -> one `framing_error` pulse, FIFO stays empty. A following good frame 0x7E is received correctly.
4. `ready`=0; send 17 frames 0x00..0x10 back-to-back -> `fifo_count`=16 and one `overflow` pulse on byte 0x10. Then `ready`=1 -> reads 0x00..0x0F in order, then `valid`=0.
5. FIFO full with `ready` pulsed high in the same cycle as the write of a new byte 0xC4 -> no `overflow`, `fifo_count` stays 16, and 0xC4 is read last. The pointers wrap correctly.
6. Assert `rst_n`=0 during data bit 4 of a frame -> all outputs return to reset values immediately. The next full frame 0x99 is received correctly.
